// File: rtl/line_mem_pkg.sv
// Shared types and helpers for the line-granular backing-memory controller.
// The queue-entry field widths set the line width and line count the controller supports.
package line_mem_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam int unsigned ENTRY_IDX_W  = 8;
    localparam int unsigned ENTRY_LINE_W = 32;

    typedef struct packed {
        logic [ENTRY_IDX_W-1:0]  idx;
        logic                    wr;
        logic [ENTRY_LINE_W-1:0] wdata;
    } req_entry_t;

    // Byte-offset bits inside one line.
    function automatic int unsigned off_width(input int unsigned line_w, input int unsigned data_w);
        return 32'($clog2(line_w) - $clog2(data_w));
    endfunction

endpackage

// File: rtl/line_mem_req_fifo.sv
// In-order request queue; pointers carry one extra wrap bit to tell full from empty.
module line_mem_req_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push_c;
    logic             do_pop_c;

    always_comb begin
        full      = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                    (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        empty     = (wr_ptr_q == rd_ptr_q);
        do_push_c = push && !full;
        do_pop_c  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule

// File: rtl/line_mem_ctrl.sv
// Backing-memory controller behind the direct-mapped cache: queues writebacks and
// fills, services them in order after LATENCY cycles, and pulses rsp_vld per fill.
module line_mem_ctrl
    import line_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned MEM_LINES  = 256,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned REQ_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_en,
    input  logic                  req_wr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  rsp_vld,
    output logic                  busy
);

    localparam int unsigned OFF_W = off_width(LINE_WIDTH, DATA_WIDTH);
    localparam int unsigned IDX_W = $clog2(MEM_LINES);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    req_entry_t            cur_q, cur_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [LINE_WIDTH-1:0] mem_q [MEM_LINES];

    req_entry_t            push_entry_c;
    req_entry_t            head_c;
    logic                  fifo_full_c;
    logic                  fifo_empty_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  mem_we_c;
    logic [IDX_W-1:0]      cur_idx_c;
    logic                  addr_unused_c;

    // Upper address bits alias onto the same line; offset bits select bytes only.
    assign addr_unused_c = ^{req_addr[ADDR_WIDTH-1:OFF_W+IDX_W], req_addr[OFF_W-1:0]};

    always_comb begin
        push_c             = req_en && !fifo_full_c;
        push_entry_c.idx   = ENTRY_IDX_W'(req_addr[OFF_W +: IDX_W]);
        push_entry_c.wr    = req_wr;
        push_entry_c.wdata = req_wr ? ENTRY_LINE_W'(req_wdata) : '0;
    end

    line_mem_req_fifo #(
        .W     ($bits(req_entry_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .din   (push_entry_c),
        .dout  (head_c),
        .full  (fifo_full_c),
        .empty (fifo_empty_c)
    );

    assign cur_idx_c = IDX_W'(cur_q.idx);

    // Next-state: pop head when idle, count down the access, then commit or respond.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        rsp_vld_d  = 1'b0;
        rsp_data_d = rsp_data_q;
        pop_c      = 1'b0;
        mem_we_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c   = 1'b1;
                    cur_d   = head_c;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (cur_q.wr) begin
                        mem_we_c = 1'b1;
                    end else begin
                        rsp_vld_d  = 1'b1;
                        rsp_data_d = mem_q[cur_idx_c];
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Backing array is intentionally left without reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[cur_idx_c] <= LINE_WIDTH'(cur_q.wdata);
        end
    end

    assign req_ready = !fifo_full_c;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty_c;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed checks of line_mem_ctrl at LATENCY=4 plus a reference-model stress run at LATENCY=1.
module tb_line_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] req_addr;
    logic        req_en;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic        rsp_vld;
    logic        busy;

    logic [15:0] req_addr1;
    logic        req_en1;
    logic        req_wr1;
    logic [31:0] req_wdata1;
    logic        req_ready1;
    logic [31:0] rsp_data1;
    logic        rsp_vld1;
    logic        busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    line_mem_ctrl #(
        .ADDR_WIDTH (16), .DATA_WIDTH (8), .LINE_WIDTH (32),
        .MEM_LINES  (256), .LATENCY (4), .REQ_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_addr  (req_addr),
        .req_en    (req_en),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_data  (rsp_data),
        .rsp_vld   (rsp_vld),
        .busy      (busy)
    );

    line_mem_ctrl #(
        .ADDR_WIDTH (16), .DATA_WIDTH (8), .LINE_WIDTH (32),
        .MEM_LINES  (256), .LATENCY (1), .REQ_DEPTH (2)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_addr  (req_addr1),
        .req_en    (req_en1),
        .req_wr    (req_wr1),
        .req_wdata (req_wdata1),
        .req_ready (req_ready1),
        .rsp_data  (rsp_data1),
        .rsp_vld   (rsp_vld1),
        .busy      (busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic [15:0] addr, input logic [31:0] data);
        req_en    = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
    endtask

    task automatic drop();
        req_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 60) begin
            tick();
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    // Runs until idle, checking each rsp_vld pulse against the expected fill data in order.
    task automatic collect(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input int n_exp);
        int got = 0;
        int k   = 0;
        do begin
            tick();
            k++;
            if (rsp_vld) begin
                if (got == 0) chk({tag, "_data0"}, rsp_data, e0);
                else if (got == 1) chk({tag, "_data1"}, rsp_data, e1);
                got++;
            end
        end while ((busy || rsp_vld) && k < 80);
        chk({tag, "_count"}, 32'(got), 32'(n_exp));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        logic [31:0] ref_mem [8];
        bit          written [8];
        logic [31:0] expq [$];
        int          issued;
        int          fills;
        int          rsps;
        int          st_idx;
        logic        st_wr;
        logic [31:0] st_data;
        logic        acc;

        rst_n = 1'b0;
        drop();
        req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        req_en1 = 1'b0; req_wr1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
        for (int i = 0; i < 8; i++) written[i] = 1'b0;
        tick(); tick(); tick();

        chk("rst_ready", 32'(req_ready), 32'(1));
        chk("rst_vld", 32'(rsp_vld), 32'(0));
        chk("rst_data", rsp_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_busy_l1", 32'(busy1), 32'(0));
        rst_n = 1'b1;
        tick();

        // Single fill of line 5 after a preloading writeback.
        req(1'b1, 16'h0014, 32'hDEADBEEF);
        tick();
        drop();
        wait_idle("preload");
        req(1'b0, 16'h0014, 32'h0);
        tick();
        drop();
        chk("fill_busy_rise", 32'(busy), 32'(1));
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("fill_vld_early", 32'(rsp_vld), 32'(0));
        end
        tick();
        chk("fill_vld", 32'(rsp_vld), 32'(1));
        chk("fill_data", rsp_data, 32'hDEADBEEF);
        chk("fill_busy_fall", 32'(busy), 32'(0));
        tick();
        chk("fill_vld_pulse", 32'(rsp_vld), 32'(0));
        chk("fill_data_hold", rsp_data, 32'hDEADBEEF);

        // Writeback then fill on back-to-back cycles.
        req(1'b1, 16'h0020, 32'h11223344);
        tick();
        chk("b2b_ready", 32'(req_ready), 32'(1));
        req(1'b0, 16'h0020, 32'h0);
        tick();
        drop();
        for (int e = 2; e <= 9; e++) begin
            tick();
            chk("b2b_vld_early", 32'(rsp_vld), 32'(0));
        end
        tick();
        chk("b2b_vld", 32'(rsp_vld), 32'(1));
        chk("b2b_data", rsp_data, 32'h11223344);
        tick();

        // Queue full: third held request must be refused.
        req(1'b1, 16'h0030, 32'hA5A5A5A5);
        tick();
        req(1'b0, 16'h0030, 32'h0);
        chk("qf_ready_a", 32'(req_ready), 32'(1));
        tick();
        req(1'b0, 16'h0014, 32'h0);
        chk("qf_ready_b", 32'(req_ready), 32'(1));
        tick();
        req(1'b0, 16'h0020, 32'h0);
        chk("qf_ready_full", 32'(req_ready), 32'(0));
        tick();
        drop();
        collect("qfull", 32'hA5A5A5A5, 32'hDEADBEEF, 2);

        // Aliasing: 0x0400 and 0x0000 share line 0.
        req(1'b1, 16'h0400, 32'hCAFEF00D);
        tick();
        req(1'b0, 16'h0000, 32'h0);
        tick();
        drop();
        collect("alias", 32'hCAFEF00D, 32'h0, 1);

        // Reset during a writeback's access leaves the old line contents.
        req(1'b1, 16'h0040, 32'h01010101);
        tick();
        drop();
        wait_idle("rst_pre");
        req(1'b1, 16'h0040, 32'h0BADBEEF);
        tick();
        drop();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_ready", 32'(req_ready), 32'(1));
        chk("arst_vld", 32'(rsp_vld), 32'(0));
        chk("arst_data", rsp_data, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req(1'b0, 16'h0040, 32'h0);
        tick();
        drop();
        collect("arst_old", 32'h01010101, 32'h0, 1);

        // LATENCY=1 stress against an in-order reference model.
        issued = 0;
        fills  = 0;
        rsps   = 0;
        for (int cyc = 0; cyc < 2000 && (issued < 50 || expq.size() > 0 || busy1); cyc++) begin
            if (issued < 50 && $urandom_range(0, 3) != 0) begin
                st_idx  = int'($urandom_range(0, 7));
                st_wr   = ($urandom_range(0, 1) == 1) || !written[st_idx];
                st_data = $urandom();
                req_en1    = 1'b1;
                req_wr1    = st_wr;
                req_addr1  = {6'($urandom()), 8'(st_idx), 2'($urandom())};
                req_wdata1 = st_data;
            end else begin
                req_en1 = 1'b0;
            end
            acc = req_en1 && req_ready1;
            tick();
            if (acc) begin
                issued++;
                if (st_wr) begin
                    ref_mem[st_idx] = st_data;
                    written[st_idx] = 1'b1;
                end else begin
                    expq.push_back(ref_mem[st_idx]);
                    fills++;
                end
            end
            if (rsp_vld1) begin
                rsps++;
                if (expq.size() > 0) chk("stress_data", rsp_data1, expq.pop_front());
            end
        end
        req_en1 = 1'b0;
        chk("stress_issued", 32'(issued), 32'(50));
        chk("stress_rsp_count", 32'(rsps), 32'(fills));
        chk("stress_pending", 32'(expq.size()), 32'(0));
        chk("stress_busy", 32'(busy1), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
